// File: rtl/keypad_scan_encoder.sv
// 4x4 keypad column scanner and key encoder behind the debounce stage.
// Optional auto-repeat while a key is held: define KEY_REPEAT_EN.
module keypad_scan_encoder #(
  parameter int unsigned SCAN_DIV    = 1000,
  parameter int unsigned RELEASE_CYC = 16,
  parameter int unsigned REPEAT_CYC  = 500000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] filas_in,
  input  logic       enable,
  output logic [3:0] columnas_out,
  output logic [3:0] key_code,
  output logic       key_valid
);

  localparam int DW_W = $clog2(SCAN_DIV);
  localparam int RW_W = $clog2(RELEASE_CYC + 1);
  localparam logic [DW_W-1:0] DWELL_LAST = DW_W'(SCAN_DIV - 1);
  localparam logic [RW_W-1:0] REL_LAST   = RW_W'(RELEASE_CYC - 1);

  typedef enum logic {S_SCAN, S_HOLD} state_t;

  state_t          state_q, state_d;
  logic [1:0]      col_q, col_d;
  logic [DW_W-1:0] dwell_q, dwell_d;
  logic [RW_W-1:0] rel_q, rel_d;
  logic [3:0]      code_q, code_d;
  logic            valid_q, valid_d;
  logic [1:0]      low_row;
  logic            rows_idle;

  function automatic logic [3:0] encode_key(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] code;
    case ({row, col})
      4'h0: code = 4'h1;  4'h1: code = 4'h2;  4'h2: code = 4'h3;  4'h3: code = 4'hA;
      4'h4: code = 4'h4;  4'h5: code = 4'h5;  4'h6: code = 4'h6;  4'h7: code = 4'hB;
      4'h8: code = 4'h7;  4'h9: code = 4'h8;  4'hA: code = 4'h9;  4'hB: code = 4'hC;
      4'hC: code = 4'hE;  4'hD: code = 4'h0;  4'hE: code = 4'hF;  default: code = 4'hD;
    endcase
    return code;
  endfunction

  function automatic logic [1:0] lowest_row(input logic [3:0] rows);
    if (!rows[0])      return 2'd0;
    else if (!rows[1]) return 2'd1;
    else if (!rows[2]) return 2'd2;
    else               return 2'd3;
  endfunction

  assign low_row   = lowest_row(filas_in);
  assign rows_idle = (filas_in == 4'b1111);

`ifdef KEY_REPEAT_EN
  localparam int RP_W = $clog2(REPEAT_CYC + 1);
  localparam logic [RP_W-1:0] RPT_LAST = RP_W'(REPEAT_CYC - 1);
  logic [RP_W-1:0] rpt_q, rpt_d;
  logic [1:0]      row_q, row_d;
`else
  if (REPEAT_CYC == 0) begin : g_repeat_unused
  end
`endif

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    dwell_d = dwell_q;
    rel_d   = rel_q;
    code_d  = code_q;
    valid_d = 1'b0;
`ifdef KEY_REPEAT_EN
    rpt_d   = rpt_q;
    row_d   = row_q;
`endif
    unique case (state_q)
      S_SCAN: begin
        // Rows are only trusted at the end of the dwell, after the column settled.
        if (dwell_q == DWELL_LAST) begin
          dwell_d = '0;
          if (enable && !rows_idle) begin
            code_d  = encode_key(low_row, col_q);
            valid_d = 1'b1;
            rel_d   = '0;
            state_d = S_HOLD;
`ifdef KEY_REPEAT_EN
            rpt_d   = '0;
            row_d   = low_row;
`endif
          end else begin
            col_d = col_q + 2'd1;
          end
        end else begin
          dwell_d = dwell_q + 1'b1;
        end
      end
      S_HOLD: begin
        if (rows_idle) begin
          if (rel_q == REL_LAST) begin
            state_d = S_SCAN;
            rel_d   = '0;
            dwell_d = '0;
            col_d   = col_q + 2'd1;
          end else begin
            rel_d = rel_q + 1'b1;
          end
        end else begin
          rel_d = '0;
        end
`ifdef KEY_REPEAT_EN
        if (!rows_idle && low_row == row_q) begin
          if (rpt_q == RPT_LAST) begin
            valid_d = 1'b1;
            rpt_d   = '0;
          end else begin
            rpt_d = rpt_q + 1'b1;
          end
        end else begin
          rpt_d = '0;
        end
`endif
      end
      default: state_d = S_SCAN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_SCAN;
      col_q   <= 2'd0;
      dwell_q <= '0;
      rel_q   <= '0;
      code_q  <= 4'h0;
      valid_q <= 1'b0;
`ifdef KEY_REPEAT_EN
      rpt_q   <= '0;
      row_q   <= 2'd0;
`endif
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      dwell_q <= dwell_d;
      rel_q   <= rel_d;
      code_q  <= code_d;
      valid_q <= valid_d;
`ifdef KEY_REPEAT_EN
      rpt_q   <= rpt_d;
      row_q   <= row_d;
`endif
    end
  end

  assign columnas_out = ~(4'b0001 << col_q);
  assign key_code     = code_q;
  assign key_valid    = valid_q;

endmodule
